// File: rtl/sdram_device_model_pkg.sv
// sdram_device_model_pkg: command encodings, error codes and burst helpers for the SDRAM responder
package sdram_device_model_pkg;
    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_BST = 4'b0110;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ACT_OPEN = 3'd1;
    localparam logic [2:0] ERR_CLOSED   = 3'd2;
    localparam logic [2:0] ERR_REF_OPEN = 3'd3;
    localparam logic [2:0] ERR_NO_MODE  = 3'd4;
    localparam logic [2:0] ERR_TRCD     = 3'd5;
    localparam logic [2:0] ERR_MODE     = 3'd6;

    // burst length kept as a wrap mask: BL1..BL8 -> 0,1,3,7
    function automatic logic [2:0] bl_to_mask(input logic [1:0] f);
        return 3'((4'd1 << f) - 4'd1);
    endfunction

    function automatic logic [2:0] wrap_lo(input logic [2:0] lo, input logic [2:0] idx, input logic [2:0] mask);
        return (lo & ~mask) | ((lo + idx) & mask);
    endfunction
endpackage

// File: rtl/sdram_device_model_bank.sv
// sdram_device_model_bank: per-bank open flag, row register and tRCD down-counter
module sdram_device_model_bank #(
    parameter int ROW_BITS = 2,
    parameter int TRCD     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                act,
    input  logic                close,
    input  logic [ROW_BITS-1:0] row_in,
    output logic                is_open,
    output logic [ROW_BITS-1:0] row,
    output logic                ready
);
    localparam int CW = TRCD > 1 ? $clog2(TRCD) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_open <= 1'b0;
            row     <= '0;
            cnt     <= '0;
        end else if (en) begin
            if (act) begin
                is_open <= 1'b1;
                row     <= row_in;
                cnt     <= CW'(TRCD - 1);
            end else begin
                if (close) is_open <= 1'b0;
                if (cnt != '0) cnt <= cnt - CW'(1);
            end
        end
    end

    assign ready = cnt == '0;
endmodule

// File: rtl/sdram_device_model.sv
// sdram_device_model: synthesizable SDRAM command responder with burst engine, CAS-latency read pipe
// and protocol-violation reporting
module sdram_device_model
    import sdram_device_model_pkg::*;
#(
    parameter int ROW_BITS   = 2,
    parameter int COL_BITS   = 8,
    parameter int TRCD       = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sdram_cke,
    input  logic                    sdram_cs_n,
    input  logic                    sdram_ras_n,
    input  logic                    sdram_cas_n,
    input  logic                    sdram_we_n,
    input  logic [1:0]              sdram_bank,
    input  logic [11:0]             sdram_addr,
    inout  wire  [DATA_WIDTH-1:0]   sdram_data,
    input  logic [DATA_WIDTH/8-1:0] sdram_dqm,
    output logic                    mode_valid,
    output logic                    proto_err,
    output logic [2:0]              err_code,
    output logic [15:0]             ref_cnt
);
    localparam int AW = 2 + ROW_BITS + COL_BITS;
    localparam int NB = DATA_WIDTH / 8;

    logic [3:0]            cmd;
    logic                  is_lmr, is_act, is_rw, is_pre, is_ref, is_bst, lmr_ok;
    logic                  rw_go, pre_hit, stop, cont, last, beat, beat_wr, ap_done;
    logic [2:0]            rw_err, err, bl_m;
    logic                  cl3;
    logic [3:0]            open_v, ready_v, act_v, close_v;
    logic [ROW_BITS-1:0]   row_v [4];
    logic                  bst_act, bst_wr, bst_ap;
    logic [1:0]            bst_bank, beat_bank;
    logic [ROW_BITS-1:0]   bst_row, beat_row;
    logic [COL_BITS-1:0]   bst_col, beat_col;
    logic [2:0]            bst_idx;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] mem [1 << AW];
    logic [DATA_WIDTH-1:0] pd [4];
    logic [3:0]            pv;
    logic                  out_v;
    logic [DATA_WIDTH-1:0] out_d;
    logic                  unused_addr;

    assign unused_addr = ^{sdram_addr[11], sdram_addr[9:8], sdram_addr[3]};

    assign cmd    = sdram_cs_n ? CMD_NOP : {1'b0, sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign is_lmr = sdram_cke && cmd == CMD_LMR;
    assign is_act = sdram_cke && cmd == CMD_ACT;
    assign is_rw  = sdram_cke && (cmd == CMD_RD || cmd == CMD_WR);
    assign is_pre = sdram_cke && cmd == CMD_PRE;
    assign is_ref = sdram_cke && cmd == CMD_REF;
    assign is_bst = sdram_cke && cmd == CMD_BST;
    assign lmr_ok = !sdram_addr[2] && sdram_addr[6:5] == 2'b01;

    assign rw_err = !mode_valid                ? ERR_NO_MODE :
                    !open_v[sdram_bank]        ? ERR_CLOSED  :
                    !ready_v[sdram_bank]       ? ERR_TRCD    : ERR_NONE;
    assign err    = (is_lmr && !lmr_ok)             ? ERR_MODE     :
                    (is_act && open_v[sdram_bank])  ? ERR_ACT_OPEN :
                    is_rw                           ? rw_err       :
                    (is_ref && |open_v)             ? ERR_REF_OPEN : ERR_NONE;

    // an accepted READ/WRITE, BURST_STOP or PRECHARGE of the bursting bank cuts the burst short
    assign rw_go   = is_rw && rw_err == ERR_NONE;
    assign pre_hit = is_pre && (sdram_addr[10] || sdram_bank == bst_bank);
    assign stop    = rw_go || is_bst || pre_hit;
    assign cont    = sdram_cke && bst_act && !stop;
    assign last    = cont && bst_idx == bl_m;
    assign beat    = rw_go || cont;

    assign beat_wr   = rw_go ? cmd == CMD_WR : bst_wr;
    assign beat_bank = rw_go ? sdram_bank : bst_bank;
    assign beat_row  = rw_go ? row_v[sdram_bank] : bst_row;
    assign beat_col  = rw_go ? sdram_addr[COL_BITS-1:0] :
                       {bst_col[COL_BITS-1:3], wrap_lo(bst_col[2:0], bst_idx, bl_m)};
    assign ap_done   = rw_go ? (bl_m == 3'd0 && sdram_addr[10]) : (last && bst_ap);
    assign addr      = {beat_bank, beat_row, beat_col};

    for (genvar b = 0; b < 4; b++) begin : g_bank
        assign act_v[b]   = is_act && sdram_bank == 2'(b) && !open_v[b];
        assign close_v[b] = (is_pre && (sdram_addr[10] || sdram_bank == 2'(b))) ||
                            (ap_done && beat_bank == 2'(b));
        sdram_device_model_bank #(
            .ROW_BITS (ROW_BITS),
            .TRCD     (TRCD)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (sdram_cke),
            .act     (act_v[b]),
            .close   (close_v[b]),
            .row_in  (sdram_addr[ROW_BITS-1:0]),
            .is_open (open_v[b]),
            .row     (row_v[b]),
            .ready   (ready_v[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bst_act  <= 1'b0;
            bst_wr   <= 1'b0;
            bst_ap   <= 1'b0;
            bst_bank <= '0;
            bst_row  <= '0;
            bst_col  <= '0;
            bst_idx  <= '0;
        end else if (sdram_cke) begin
            if (rw_go) begin
                bst_act  <= bl_m != 3'd0;
                bst_wr   <= cmd == CMD_WR;
                bst_ap   <= sdram_addr[10];
                bst_bank <= sdram_bank;
                bst_row  <= row_v[sdram_bank];
                bst_col  <= sdram_addr[COL_BITS-1:0];
                bst_idx  <= 3'd1;
            end else if (stop || last) begin
                bst_act <= 1'b0;
            end else if (cont) begin
                bst_idx <= bst_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_valid <= 1'b0;
            bl_m       <= '0;
            cl3        <= 1'b0;
            proto_err  <= 1'b0;
            err_code   <= ERR_NONE;
            ref_cnt    <= '0;
        end else begin
            proto_err <= err != ERR_NONE;
            if (err != ERR_NONE) err_code <= err;
            if (is_lmr && lmr_ok) begin
                mode_valid <= 1'b1;
                bl_m       <= bl_to_mask(sdram_addr[1:0]);
                cl3        <= sdram_addr[4];
            end
            if (is_ref) ref_cnt <= ref_cnt + 16'd1;
        end
    end

    // read data is captured at the beat's issue edge then aged CL edges before reaching dq
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pv <= '0;
        else if (sdram_cke) pv <= {pv[2:0], beat && !beat_wr};
    end

    always_ff @(posedge clk) begin
        if (sdram_cke) begin
            pd[0] <= mem[addr];
            pd[1] <= pd[0];
            pd[2] <= pd[1];
            pd[3] <= pd[2];
            if (beat && beat_wr)
                for (int i = 0; i < NB; i++)
                    if (!sdram_dqm[i]) mem[addr][8*i +: 8] <= sdram_data[8*i +: 8];
        end
    end

    assign out_v      = cl3 ? pv[3] : pv[2];
    assign out_d      = cl3 ? pd[3] : pd[2];
    assign sdram_data = out_v ? out_d : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_sdram_device_model.sv
// tb_sdram_device_model: randomized and directed checks of the SDRAM responder against a
// word-array reference model; an undriven bus reads as all ones through the pulled-up net
module tb_sdram_device_model;
    localparam logic [3:0] LMR = 4'b0000, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, BST = 4'b0110, NOP = 4'b0111;
    localparam logic [15:0] HIZ = 16'hffff;

    logic        clk = 0, rst_n = 0, cke = 1, tb_oe = 0;
    logic        cs_n = 1, ras_n = 1, cas_n = 1, we_n = 1;
    logic [1:0]  bank = 0, dqm = 0;
    logic [11:0] addr = 0;
    logic [15:0] tb_dq = 0;
    logic        mode_valid, proto_err;
    logic [2:0]  err_code;
    logic [15:0] ref_cnt;
    tri1  [15:0] dq;

    int          n_chk = 0, n_fail = 0;
    int          m_bl = 1, m_cl = 2;
    int          m_row [4];
    logic [15:0] mem_m [4096];
    logic [15:0] wd [8];
    logic [1:0]  wm [8];

    assign dq = tb_oe ? tb_dq : 16'hzzzz;
    always #5 clk = ~clk;

    sdram_device_model dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sdram_cke   (cke),
        .sdram_cs_n  (cs_n),
        .sdram_ras_n (ras_n),
        .sdram_cas_n (cas_n),
        .sdram_we_n  (we_n),
        .sdram_bank  (bank),
        .sdram_addr  (addr),
        .sdram_data  (dq),
        .sdram_dqm   (dqm),
        .mode_valid  (mode_valid),
        .proto_err   (proto_err),
        .err_code    (err_code),
        .ref_cnt     (ref_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a);
        {cs_n, ras_n, cas_n, we_n} = c;
        bank = b;
        addr = a;
    endtask

    task automatic nop();
        drive(NOP, 2'd0, 12'd0);
    endtask

    task automatic cmd_chk(input string tag, input logic [3:0] c, input logic [1:0] b,
                           input logic [11:0] a, input logic [2:0] exp);
        drive(c, b, a);
        step();
        nop();
        check({tag, "_pulse"}, proto_err, exp != 0);
        if (exp != 0) check({tag, "_code"}, err_code, exp);
    endtask

    task automatic set_mode(input int bl_f, input int cl);
        cmd_chk("lmr", LMR, 2'd0, {5'd0, 3'(cl), 1'b0, 3'(bl_f)}, 3'd0);
        m_bl = 1 << bl_f;
        m_cl = cl;
    endtask

    // word address of beat k: sequential wrap inside the BL-aligned column block
    function automatic int ma(input int b, input int col, input int k);
        return b * 1024 + (m_row[b] % 4) * 256 + (col / m_bl) * m_bl + (col + k) % m_bl;
    endfunction

    task automatic wr(input int b, input int col);
        int a;
        drive(WR, 2'(b), 12'(col));
        tb_oe = 1;
        for (int k = 0; k < m_bl; k++) begin
            a = ma(b, col, k);
            tb_dq = wd[k];
            dqm = wm[k];
            if (!wm[k][0]) mem_m[a][7:0] = wd[k][7:0];
            if (!wm[k][1]) mem_m[a][15:8] = wd[k][15:8];
            step();
            if (k == 0) check("wr_err", proto_err, 0);
            nop();
        end
        tb_oe = 0;
        dqm = 0;
    endtask

    task automatic rd(input int b, input int col, input logic ap, input int stop_at, input int stall_at);
        logic [15:0] exp_d [8];
        logic [15:0] ev;
        int nb, e, st;
        logic stalled;
        for (int k = 0; k < m_bl; k++) exp_d[k] = mem_m[ma(b, col, k)];
        nb = (stop_at != 0 && stop_at < m_bl) ? stop_at : m_bl;
        drive(RD, 2'(b), {1'b0, ap, 10'(col)});
        step();
        nop();
        check("rd_err", proto_err, 0);
        check("rd_dq_cmd", dq, HIZ);
        e = 0;
        st = 0;
        for (int t = 0; t < m_cl + m_bl + 4; t++) begin
            stalled = stall_at != 0 && e == stall_at && st < 2;
            cke = !stalled;
            if (stalled) st++;
            if (!stalled && stop_at != 0 && e + 1 == stop_at) drive(BST, 2'd0, 12'd0);
            step();
            nop();
            cke = 1;
            if (!stalled) e++;
            ev = (e >= m_cl && e - m_cl < nb) ? exp_d[e - m_cl] : HIZ;
            check("rd_dq", dq, ev);
        end
    endtask

    initial begin
        nop();
        step();
        step();
        check("rst_mode_valid", mode_valid, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_ref_cnt", ref_cnt, 0);
        check("rst_dq", dq, HIZ);
        rst_n = 1;
        step();

        cmd_chk("rd_no_mode", RD, 2'd0, 12'h010, 3'd4);
        for (int i = 0; i < 4; i++) begin
            check("no_mode_dq", dq, HIZ);
            step();
        end

        set_mode(2, 2);
        check("mode_valid", mode_valid, 1);
        m_row[0] = 1;
        cmd_chk("act0", ACT, 2'd0, 12'd1, 3'd0);
        step();
        wd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 16'h0};
        wm = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        wr(0, 'h10);
        rd(0, 'h10, 1'b0, 0, 0);

        wd = '{16'h5a5a, 16'h6b6b, 16'h7c7c, 16'h0d0d, 16'h0, 16'h0, 16'h0, 16'h0};
        wm = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        wr(0, 'h10);
        rd(0, 'h10, 1'b0, 0, 0);

        set_mode(3, 3);
        for (int k = 0; k < 8; k++) begin
            wd[k] = 16'($urandom) & 16'h7fff;
            wm[k] = 2'b00;
        end
        wr(0, 'h0e);
        rd(0, 'h0e, 1'b0, 0, 0);
        rd(0, 'h0e, 1'b0, 0, 2);

        cmd_chk("lmr_bad_cl", LMR, 2'd0, 12'h042, 3'd6);
        cmd_chk("lmr_bad_bl", LMR, 2'd0, 12'h024, 3'd6);
        check("mode_kept", mode_valid, 1);
        rd(0, 'h0e, 1'b0, 0, 0);

        cmd_chk("act1", ACT, 2'd1, 12'd5, 3'd0);
        cmd_chk("rd_trcd", RD, 2'd1, 12'd0, 3'd5);
        cmd_chk("act_open", ACT, 2'd1, 12'd6, 3'd1);
        cmd_chk("rd_closed", RD, 2'd3, 12'd0, 3'd2);
        cmd_chk("act2", ACT, 2'd2, 12'd0, 3'd0);
        cmd_chk("ref_open", REF, 2'd0, 12'd0, 3'd3);
        check("ref_cnt1", ref_cnt, 1);
        cmd_chk("pre_all", PRE, 2'd0, 12'h400, 3'd0);
        cmd_chk("ref_ok", REF, 2'd0, 12'd0, 3'd0);
        check("ref_cnt2", ref_cnt, 2);
        check("err_code_held", err_code, 3);

        set_mode(2, 2);
        cmd_chk("act0b", ACT, 2'd0, 12'd1, 3'd0);
        step();
        rd(0, 'h10, 1'b0, 2, 0);
        cmd_chk("pre_all2", PRE, 2'd0, 12'h400, 3'd0);

        for (int i = 0; i < 24; i++) begin
            int b, col;
            logic ap;
            set_mode($urandom_range(0, 3), $urandom_range(2, 3));
            b = $urandom_range(0, 3);
            m_row[b] = $urandom_range(0, 4095);
            cmd_chk("act_rnd", ACT, 2'(b), 12'(m_row[b]), 3'd0);
            step();
            col = $urandom_range(0, 255);
            for (int k = 0; k < 8; k++) begin
                wd[k] = 16'($urandom) & 16'h7fff;
                wm[k] = 2'b00;
            end
            wr(b, col);
            for (int k = 0; k < 8; k++) begin
                wd[k] = 16'($urandom) & 16'h7fff;
                wm[k] = 2'($urandom);
            end
            wr(b, col);
            ap = 1'($urandom);
            rd(b, col, ap, 0, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            cmd_chk("ap_close", ACT, 2'(b), 12'(m_row[b]), ap ? 3'd0 : 3'd1);
            cmd_chk("pre_rnd", PRE, 2'd0, 12'h400, 3'd0);
        end

        set_mode(2, 2);
        m_row[0] = 1;
        cmd_chk("act0c", ACT, 2'd0, 12'd1, 3'd0);
        step();
        drive(RD, 2'd0, 12'h010);
        step();
        nop();
        step();
        step();
        check("mid_burst_dq", dq, mem_m[ma(0, 'h10, 0)]);
        rst_n = 0;
        #1;
        check("async_rst_dq", dq, HIZ);
        check("async_rst_mode", mode_valid, 0);
        check("async_rst_ref", ref_cnt, 0);
        check("async_rst_err", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
